// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage valid/ready immediate generator for decode.
// Extends I/D/B/CB fields, builds MOVZ/MOVK values, flags illegal modes.
module imm_gen_pipe #(
   parameter int DATA_W   = 64,
   parameter int SCALE_BR = 0,
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_ctrl,
   input  logic [25:0]         in_imm26,
   input  logic [DATA_W-1:0]   in_old,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_imm,
   output logic                out_err,
   output logic [ERRCNT_W-1:0] err_count
);

   generate
      if (DATA_W != 32 && DATA_W != 64) begin : g_bad_w
         $error("imm_gen_pipe: DATA_W must be 32 or 64");
      end
   endgenerate

   typedef struct packed {
      logic [3:0]        ctrl;
      logic [25:0]       imm26;
      logic [DATA_W-1:0] old;
      logic              illegal;
   } s1_t;

   logic              s1_valid;
   s1_t               s1;
   logic              s1_adv;
   logic              s2_adv;
   logic              accept;
   logic              in_illegal;

   assign s2_adv   = !out_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;
   assign accept   = in_valid & s1_adv;

   // upper halfwords do not exist on a 32-bit datapath
   always_comb begin
      in_illegal = in_ctrl[3] & in_ctrl[2];
      if (DATA_W == 32 && (in_ctrl[3] ^ in_ctrl[2]) && in_ctrl[1])
         in_illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.ctrl    <= in_ctrl;
            s1.imm26   <= in_imm26;
            s1.old     <= in_old;
            s1.illegal <= in_illegal;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (accept && in_illegal && !(&err_count))
         err_count <= err_count + ERRCNT_W'(1);
   end

   logic              sel_i;
   logic              sel_d;
   logic              sel_b;
   logic              sel_cb;
   logic              sel_movz;
   logic              sel_movk;
   logic [5:0]        hw_sh;
   logic [DATA_W-1:0] ext_i;
   logic [DATA_W-1:0] ext_d;
   logic [DATA_W-1:0] ext_b;
   logic [DATA_W-1:0] ext_cb;
   logic [DATA_W-1:0] br_b;
   logic [DATA_W-1:0] br_cb;
   logic [DATA_W-1:0] wide16;
   logic [DATA_W-1:0] hw_mask;
   logic [DATA_W-1:0] res;

   assign sel_i    = !s1.illegal & (s1.ctrl == 4'd0);
   assign sel_d    = !s1.illegal & (s1.ctrl == 4'd1);
   assign sel_b    = !s1.illegal & (s1.ctrl == 4'd2);
   assign sel_cb   = !s1.illegal & (s1.ctrl == 4'd3);
   assign sel_movz = !s1.illegal & (s1.ctrl[3:2] == 2'b01);
   assign sel_movk = !s1.illegal & (s1.ctrl[3:2] == 2'b10);

   assign hw_sh  = {s1.ctrl[1:0], 4'b0000};
   assign ext_i  = DATA_W'(s1.imm26[21:10]);
   assign ext_d  = {{(DATA_W-9){s1.imm26[20]}}, s1.imm26[20:12]};
   assign ext_b  = {{(DATA_W-26){s1.imm26[25]}}, s1.imm26};
   assign ext_cb = {{(DATA_W-19){s1.imm26[23]}}, s1.imm26[23:5]};

   generate
      if (SCALE_BR != 0) begin : g_scale
         assign br_b  = ext_b << 2;
         assign br_cb = ext_cb << 2;
      end else begin : g_noscale
         assign br_b  = ext_b;
         assign br_cb = ext_cb;
      end
   endgenerate

   assign wide16  = DATA_W'(s1.imm26[20:5]) << hw_sh;
   assign hw_mask = DATA_W'(16'hFFFF) << hw_sh;

   // illegal modes fall through to the zero default
   always_comb begin
      res = '0;
      unique case (1'b1)
         sel_i:    res = ext_i;
         sel_d:    res = ext_d;
         sel_b:    res = br_b;
         sel_cb:   res = br_cb;
         sel_movz: res = wide16;
         sel_movk: res = (s1.old & ~hw_mask) | wide16;
         default:  res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_err   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_imm <= res;
            out_err <= s1.illegal;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving three imm_gen_pipe builds
// (64-bit, 64-bit scaled, 32-bit scaled with 2-bit counter) in lockstep.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [3:0]  in_ctrl;
   logic [25:0] in_imm26;
   logic [63:0] in_old;

   logic        rdy0, rdy1, rdy2;
   logic        ov0, ov1, ov2;
   logic        oe0, oe1, oe2;
   logic [63:0] imm0, imm1;
   logic [31:0] imm2;
   logic [15:0] ec0, ec1;
   logic [1:0]  ec2;

   logic        ov[3];
   logic        oe[3];
   logic [63:0] oi[3];

   assign ov[0] = ov0;
   assign ov[1] = ov1;
   assign ov[2] = ov2;
   assign oe[0] = oe0;
   assign oe[1] = oe1;
   assign oe[2] = oe2;
   assign oi[0] = imm0;
   assign oi[1] = imm1;
   assign oi[2] = {32'd0, imm2};

   imm_gen_pipe #(.DATA_W(64), .SCALE_BR(0), .ERRCNT_W(16)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
      .in_ctrl(in_ctrl), .in_imm26(in_imm26), .in_old(in_old),
      .out_valid(ov0), .out_ready(out_ready), .out_imm(imm0),
      .out_err(oe0), .err_count(ec0));

   imm_gen_pipe #(.DATA_W(64), .SCALE_BR(1), .ERRCNT_W(16)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
      .in_ctrl(in_ctrl), .in_imm26(in_imm26), .in_old(in_old),
      .out_valid(ov1), .out_ready(out_ready), .out_imm(imm1),
      .out_err(oe1), .err_count(ec1));

   imm_gen_pipe #(.DATA_W(32), .SCALE_BR(1), .ERRCNT_W(2)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
      .in_ctrl(in_ctrl), .in_imm26(in_imm26), .in_old(in_old[31:0]),
      .out_valid(ov2), .out_ready(out_ready), .out_imm(imm2),
      .out_err(oe2), .err_count(ec2));

   typedef struct {
      logic [63:0] v;
      logic        e;
      int          cyc;
   } ent_t;

   ent_t q[3][$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ec_m[3];
   bit   lat_on = 1'b0;
   bit   rnd_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [64:0] model(input int dw, input bit sc,
                                         input logic [3:0] c,
                                         input logic [25:0] i,
                                         input logic [63:0] old);
      logic [63:0] v;
      logic        e;
      int          hw;
      v  = '0;
      e  = 1'b0;
      hw = int'(c[1:0]);
      case (c)
         4'd0: v = {52'd0, i[21:10]};
         4'd1: v = {{55{i[20]}}, i[20:12]};
         4'd2: v = {{38{i[25]}}, i};
         4'd3: v = {{45{i[23]}}, i[23:5]};
         4'd4, 4'd5, 4'd6, 4'd7:
            if (dw == 32 && hw >= 2) e = 1'b1;
            else v = {48'd0, i[20:5]} << (16 * hw);
         4'd8, 4'd9, 4'd10, 4'd11:
            if (dw == 32 && hw >= 2) e = 1'b1;
            else begin
               v = old;
               v[16*hw +: 16] = i[20:5];
            end
         default: e = 1'b1;
      endcase
      if (sc && (c == 4'd2 || c == 4'd3)) v = v << 2;
      if (dw == 32) v[63:32] = '0;
      return {e, v};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [64:0] x0, input logic [64:0] x1,
                           input logic [64:0] x2);
      logic [64:0] x[3];
      ent_t        en;
      x[0] = x0;
      x[1] = x1;
      x[2] = x2;
      for (int k = 0; k < 3; k++) begin
         en.v   = x[k][63:0];
         en.e   = x[k][64];
         en.cyc = cyc;
         q[k].push_back(en);
         if (en.e) ec_m[k]++;
      end
      if (ec_m[2] > 3) ec_m[2] = 3;
   endtask

   task automatic send_x(input logic [3:0] c, input logic [25:0] i,
                         input logic [63:0] old, input logic [64:0] x0,
                         input logic [64:0] x1, input logic [64:0] x2);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_ctrl  = c;
      in_imm26 = i;
      in_old   = old;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         acc = rdy0 && !reset;
         if (acc) push_exp(x0, x1, x2);
         tick();
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic send(input logic [3:0] c, input logic [25:0] i,
                       input logic [63:0] old);
      send_x(c, i, old, model(64, 1'b0, c, i, old),
             model(64, 1'b1, c, i, old),
             model(32, 1'b1, c, i, {32'd0, old[31:0]}));
   endtask

   task automatic drain;
      for (int n = 0; n < 60; n++) begin
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0)
            break;
         tick();
      end
      chk("drain", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
   endtask

   task automatic flush;
      for (int k = 0; k < 3; k++) begin
         q[k].delete();
         ec_m[k] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && out_ready) begin
               if (q[k].size() == 0) begin
                  chk($sformatf("unexp_out%0d", k), 64'(ov[k]), 64'd0);
               end else begin
                  ent_t en;
                  en = q[k].pop_front();
                  chk($sformatf("imm%0d", k), oi[k], en.v);
                  chk($sformatf("err%0d", k), 64'(oe[k]), 64'(en.e));
                  if (lat_on)
                     chk($sformatf("lat%0d", k), 64'(cyc - en.cyc), 64'd2);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:0] xa;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_imm26  = '0;
      in_old    = '0;
      out_ready = 1'b1;
      flush();
      tick();
      tick();
      reset = 1'b0;

      @(negedge clk);
      chk("rst_in_ready", 64'(rdy0), 64'd1);
      chk("rst_out_valid", 64'(ov0), 64'd0);
      chk("rst_out_imm", imm0, 64'd0);
      chk("rst_out_err", 64'(oe0), 64'd0);
      chk("rst_err_count", 64'(ec0), 64'd0);
      tick();

      // back-to-back stream, fixed latency
      lat_on = 1'b1;
      send_x(4'd0, 26'h03FFC00, 64'd0, {1'b0, 64'h0000_0000_0000_0FFF},
             {1'b0, 64'h0000_0000_0000_0FFF},
             {1'b0, 64'h0000_0000_0000_0FFF});
      send_x(4'd1, 26'h01FF000, 64'd0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF},
             {1'b0, 64'hFFFF_FFFF_FFFF_FFFF},
             {1'b0, 64'h0000_0000_FFFF_FFFF});
      send_x(4'd3, 26'h0800000, 64'd0, {1'b0, 64'hFFFF_FFFF_FFFC_0000},
             {1'b0, 64'hFFFF_FFFF_FFF0_0000},
             {1'b0, 64'h0000_0000_FFF0_0000});
      drain();
      lat_on = 1'b0;

      send_x(4'd2, 26'h0000001, 64'd0, {1'b0, 64'h1}, {1'b0, 64'h4},
             {1'b0, 64'h4});
      send_x(4'd9, 26'h01579A0, 64'h1111_2222_3333_4444,
             {1'b0, 64'h1111_2222_ABCD_4444},
             {1'b0, 64'h1111_2222_ABCD_4444},
             {1'b0, 64'h0000_0000_ABCD_4444});
      send_x(4'd7, 26'h01579A0, 64'd0, {1'b0, 64'hABCD_0000_0000_0000},
             {1'b0, 64'hABCD_0000_0000_0000}, {1'b1, 64'd0});
      send_x(4'd6, 26'h01579A0, 64'd0, {1'b0, 64'h0000_ABCD_0000_0000},
             {1'b0, 64'h0000_ABCD_0000_0000}, {1'b1, 64'd0});
      send_x(4'd13, 26'h3FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, {1'b1, 64'd0},
             {1'b1, 64'd0}, {1'b1, 64'd0});
      drain();
      chk("ec_after13_u0", 64'(ec0), 64'd1);
      chk("ec_after13_u1", 64'(ec1), 64'd1);
      chk("ec_after13_u2", 64'(ec2), 64'd3);

      // backpressure: two held, third stalls
      out_ready = 1'b0;
      send(4'd8, 26'h01579A0, 64'h1111_2222_3333_4444);
      send(4'd4, 26'h0012340, 64'd0);
      xa = model(64, 1'b0, 4'd8, 26'h01579A0, 64'h1111_2222_3333_4444);
      in_valid = 1'b1;
      in_ctrl  = 4'd0;
      in_imm26 = 26'h03FFC00;
      in_old   = 64'd0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(rdy0), 64'd0);
         chk("bp_out_valid", 64'(ov0), 64'd1);
         chk("bp_hold_imm", imm0, xa[63:0]);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(rdy0), 64'd1);
      push_exp(model(64, 1'b0, 4'd0, 26'h03FFC00, 64'd0),
               model(64, 1'b1, 4'd0, 26'h03FFC00, 64'd0),
               model(32, 1'b1, 4'd0, 26'h03FFC00, 64'd0));
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_second_out", 64'(ov0), 64'd1);
      tick();
      @(negedge clk);
      chk("bp_third_out", 64'(ov0), 64'd1);
      tick();
      drain();

      // random traffic with random backpressure
      rnd_rdy = 1'b1;
      for (int n = 0; n < 40; n++)
         send(4'($urandom_range(0, 15)), 26'($urandom),
              {$urandom, $urandom});
      rnd_rdy   = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("rnd_ec_u0", 64'(ec0), 64'(ec_m[0]));
      chk("rnd_ec_u1", 64'(ec1), 64'(ec_m[1]));
      chk("rnd_ec_u2", 64'(ec2), 64'(ec_m[2]));

      // reset with two results in flight
      out_ready = 1'b0;
      send(4'd0, 26'h0155400, 64'd0);
      send(4'd14, 26'h0, 64'd0);
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 4'd14;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      flush();
      @(negedge clk);
      chk("mrst_out_valid", 64'(ov0), 64'd0);
      chk("mrst_err_count", 64'(ec0), 64'd0);
      chk("mrst_in_ready", 64'(rdy0), 64'd1);
      tick();
      repeat (5) tick();
      chk("mrst_no_stale_ec", 64'(ec0), 64'd0);

      // counter saturation on the 2-bit build
      for (int n = 0; n < 5; n++)
         send_x(4'd15, 26'($urandom), 64'd0, {1'b1, 64'd0},
                {1'b1, 64'd0}, {1'b1, 64'd0});
      drain();
      chk("sat_ec_u2", 64'(ec2), 64'd3);
      chk("sat_ec_u0", 64'(ec0), 64'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
